// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for hazard_ctrl: decode/execute/memory/write-back
// register tags in, forwarding selects and stall/flush/freeze controls out.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              id_is_branch;
  logic              id_branch_taken;
  logic [REG_AW-1:0] ex_rw;
  logic              ex_regwrite;
  logic              ex_mem2reg;
  logic [REG_AW-1:0] mem_rw;
  logic              mem_regwrite;
  logic              mem_mem2reg;
  logic [REG_AW-1:0] wb_rw;
  logic              wb_regwrite;
  logic              mem_req;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              stall_if;
  logic              stall_id;
  logic              bubble_ex;
  logic              flush_ifid;
  logic              freeze_all;

  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used,
    output id_is_branch, id_branch_taken,
    output ex_rw, ex_regwrite, ex_mem2reg,
    output mem_rw, mem_regwrite, mem_mem2reg,
    output wb_rw, wb_regwrite, mem_req,
    input  fwd_a_sel, fwd_b_sel, stall_if, stall_id,
    input  bubble_ex, flush_ifid, freeze_all
  );

  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used,
    input  id_is_branch, id_branch_taken,
    input  ex_rw, ex_regwrite, ex_mem2reg,
    input  mem_rw, mem_regwrite, mem_mem2reg,
    input  wb_rw, wb_regwrite, mem_req,
    output fwd_a_sel, fwd_b_sel, stall_if, stall_id,
    output bubble_ex, flush_ifid, freeze_all
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard detection, forwarding and memory-wait freeze for the 5-stage pipe.
// Define HAZARD_CTRL_PERF_EN to add stall/flush/freeze cycle counters.
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int MEM_LAT    = 1,
  parameter int DELAY_SLOT = 1
) (
  input  logic         clock,
  input  logic         reset,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]  stall_cycles,
  output logic [31:0]  flush_count,
  output logic [31:0]  freeze_cycles
`endif
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam bit         MULTI  = (MEM_LAT > 1);
  localparam bit         NO_DS  = (DELAY_SLOT == 0);
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [REG_AW-1:0] r_ex_rs;
  logic [REG_AW-1:0] r_ex_rt;
  logic              r_ex_rs_used;
  logic              r_ex_rt_used;

  logic       w_freeze;
  logic       w_hit_ex;
  logic       w_hit_mem;
  logic       w_load_use;
  logic       w_br_haz;
  logic       w_hazard;
  logic       w_stall;
  logic       w_flush;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  function automatic logic hit(
    input logic              used,
    input logic [REG_AW-1:0] src,
    input logic [REG_AW-1:0] dst
  );
    return used && (src != '0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd(
    input logic              used,
    input logic [REG_AW-1:0] src,
    input logic              m_hit,
    input logic              w_hit
  );
    logic l_ok;
    l_ok = used && (src != '0);
    unique case (1'b1)
      (l_ok && m_hit):           return 2'd1;
      (l_ok && !m_hit && w_hit): return 2'd2;
      default:                   return 2'd0;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (hz.mem_req && MULTI) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = LAT_M1;
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_freeze = 1'b0;
    unique case (r_state)
      S_IDLE:  w_freeze = hz.mem_req && MULTI;
      S_WAIT:  w_freeze = (r_cnt > 4'd1);
      default: w_freeze = 1'b0;
    endcase
  end

  // write-back producers need no stall: the regfile writes before it reads
  assign w_hit_ex = hit(hz.id_rs_used, hz.id_rs, hz.ex_rw) |
                    hit(hz.id_rt_used, hz.id_rt, hz.ex_rw);
  assign w_hit_mem = hit(hz.id_rs_used, hz.id_rs, hz.mem_rw) |
                     hit(hz.id_rt_used, hz.id_rt, hz.mem_rw);
  assign w_load_use = hz.ex_regwrite && hz.ex_mem2reg && w_hit_ex;
  assign w_br_haz = hz.id_is_branch &&
                    ((hz.ex_regwrite && w_hit_ex) ||
                     (hz.mem_regwrite && hz.mem_mem2reg && w_hit_mem));
  assign w_hazard = w_load_use || w_br_haz;
  assign w_stall  = w_hazard && !w_freeze && !reset;
  assign w_flush  = hz.id_branch_taken && NO_DS && !w_hazard &&
                    !w_freeze && !reset;

  always_ff @(posedge clock) begin
    if (reset || w_stall) begin
      r_ex_rs      <= '0;
      r_ex_rt      <= '0;
      r_ex_rs_used <= 1'b0;
      r_ex_rt_used <= 1'b0;
    end else if (!w_freeze) begin
      r_ex_rs      <= hz.id_rs;
      r_ex_rt      <= hz.id_rt;
      r_ex_rs_used <= hz.id_rs_used;
      r_ex_rt_used <= hz.id_rt_used;
    end
  end

  assign w_fwd_a = fwd(r_ex_rs_used, r_ex_rs,
    hz.mem_regwrite && !hz.mem_mem2reg && (hz.mem_rw == r_ex_rs),
    hz.wb_regwrite && (hz.wb_rw == r_ex_rs));
  assign w_fwd_b = fwd(r_ex_rt_used, r_ex_rt,
    hz.mem_regwrite && !hz.mem_mem2reg && (hz.mem_rw == r_ex_rt),
    hz.wb_regwrite && (hz.wb_rw == r_ex_rt));

  assign hz.fwd_a_sel  = reset ? 2'd0 : w_fwd_a;
  assign hz.fwd_b_sel  = reset ? 2'd0 : w_fwd_b;
  assign hz.stall_if   = w_stall;
  assign hz.stall_id   = w_stall;
  assign hz.bubble_ex  = w_stall;
  assign hz.flush_ifid = w_flush;
  assign hz.freeze_all = w_freeze && !reset;

`ifdef HAZARD_CTRL_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles  <= '0;
      flush_count   <= '0;
      freeze_cycles <= '0;
    end else begin
      if (w_stall)  stall_cycles  <= stall_cycles + 32'd1;
      if (w_flush)  flush_count   <= flush_count + 32'd1;
      if (w_freeze) freeze_cycles <= freeze_cycles + 32'd1;
    end
  end
`endif

endmodule
